// File: rtl/nvram_pkg.sv
// Shared types for the HPS upload (save-to-SD) path.
package nvram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPause,
    StReady,
    StFetch,
    StLat,
    StDrain
  } state_e;

  localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/nvram_upload.sv
// Serves HPS ioctl upload reads from game work RAM while the core is held paused.
// The core is paused through a req/ack handshake; reads go through a shared RAM read port.
module nvram_upload
  import nvram_pkg::*;
#(
  parameter logic [7:0]  INDEX   = 8'd4,
  parameter int unsigned AW      = 11,
  parameter int unsigned SIZE    = 2048,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  output logic          timeout_flag
);

  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
  localparam logic [24:0]   SIZE_A   = 25'(SIZE);
  localparam logic [1:0]    LAT_LAST = 2'(RD_LAT);

  state_e        state_q, state_d;
  logic          active_q;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]    lat_q, lat_d;
  logic [7:0]    din_q, din_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          flag_q, flag_d;

  logic active;
  logic in_range;

  assign active   = ioctl_upload && (ioctl_index == INDEX);
  assign in_range = ioctl_addr < SIZE_A;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      active_q <= 1'b0;
      to_cnt_q <= '0;
      lat_q    <= '0;
      din_q    <= '0;
      addr_q   <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active;
      to_cnt_q <= to_cnt_d;
      lat_q    <= lat_d;
      din_q    <= din_d;
      addr_q   <= addr_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    lat_d    = lat_q;
    din_d    = din_q;
    addr_d   = addr_q;
    flag_d   = flag_q;
    unique case (state_q)
      StIdle: begin
        if (active && !active_q) begin
          state_d  = StPause;
          to_cnt_d = '0;
          flag_d   = 1'b0;
        end
      end
      StPause: begin
        if (!active) begin
          state_d = StDrain;
        end else if (pause_ack) begin
          state_d = StReady;
        end else begin
          if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + TW'(1);
          // Give up waiting for the core after TIMEOUT cycles and serve reads anyway.
          if (to_cnt_d == TO_MAX) begin
            state_d = StReady;
            flag_d  = 1'b1;
          end
        end
      end
      StReady: begin
        if (!active) begin
          state_d = StDrain;
        end else if (ioctl_rd) begin
          if (in_range) begin
            addr_d  = ioctl_addr[AW-1:0];
            state_d = StFetch;
          end else begin
            din_d = FILL_BYTE;
          end
        end
      end
      StFetch: begin
        lat_d   = 2'd1;
        state_d = StLat;
      end
      StLat: begin
        // An in-flight read always completes before pause_req is released.
        if (lat_q == LAT_LAST) begin
          din_d   = ram_q;
          state_d = active ? StReady : StDrain;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pause_req    = (state_q == StPause) || (state_q == StReady) ||
                   (state_q == StFetch) || (state_q == StLat);
    ram_rd       = (state_q == StFetch);
    // Stall from the strobe cycle itself so HPS never samples stale data.
    ioctl_wait   = (state_q == StPause) || (state_q == StFetch) || (state_q == StLat) ||
                   (ioctl_rd && active && (state_q == StReady) && in_range);
    ioctl_din    = din_q;
    ram_addr     = addr_q;
    timeout_flag = flag_q;
  end

endmodule

// File: tb/tb_nvram_upload.sv
// Directed self-checking bench for nvram_upload with a 1-cycle-latency RAM model.
module tb_nvram_upload;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        pause_req;
  logic        pause_ack;
  logic [10:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_q;
  logic        timeout_flag;

  logic [7:0] mem [0:2047];
  int n_cmp = 0;
  int n_bad = 0;
  int rd_pulses = 0;

  always #5 clk_sys = ~clk_sys;

  nvram_upload dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .pause_req    (pause_req),
    .pause_ack    (pause_ack),
    .ram_addr     (ram_addr),
    .ram_rd       (ram_rd),
    .ram_q        (ram_q),
    .timeout_flag (timeout_flag)
  );

  always @(posedge clk_sys) begin
    if (ram_rd) begin
      ram_q     <= mem[ram_addr];
      rd_pulses <= rd_pulses + 1;
    end
  end

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_sys);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int p0;
    logic hi;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[11'h123] = 8'h5A;
    mem[11'h7FF] = 8'hA3;
    mem[11'h010] = 8'hC7;
    ram_q        = 8'h00;
    reset        = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    pause_ack    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_sys);
    smp();
    check("rst_din", ioctl_din, 8'h00);
    check("rst_wait", ioctl_wait, 1'b0);
    check("rst_pause_req", pause_req, 1'b0);
    check("rst_ram_rd", ram_rd, 1'b0);
    check("rst_ram_addr", ram_addr, 11'h000);
    check("rst_timeout_flag", timeout_flag, 1'b0);
    cyc();
    reset = 1'b0;

    // Upload start, pause_ack arrives in the 10th PAUSE cycle
    cyc();
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    cyc();
    smp();
    check("pause_req_up", pause_req, 1'b1);
    check("pause_wait_first", ioctl_wait, 1'b1);
    hi = 1'b1;
    for (int i = 2; i <= 10; i++) begin
      cyc();
      if (i == 10) pause_ack = 1'b1;
      smp();
      hi = hi & ioctl_wait;
    end
    check("pause_wait_10_cycles", hi, 1'b1);
    cyc();
    smp();
    check("ready_wait_low", ioctl_wait, 1'b0);
    check("ready_flag_clear", timeout_flag, 1'b0);

    // In-range read of 0x123
    p0 = rd_pulses;
    cyc();
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h123;
    smp();
    check("rd_strobe_wait", ioctl_wait, 1'b1);
    cyc();
    ioctl_rd = 1'b0;
    smp();
    check("fetch_ram_rd", ram_rd, 1'b1);
    check("fetch_ram_addr", ram_addr, 11'h123);
    check("fetch_wait", ioctl_wait, 1'b1);
    cyc();
    smp();
    check("lat_ram_rd_low", ram_rd, 1'b0);
    check("lat_wait", ioctl_wait, 1'b1);
    cyc();
    smp();
    check("rd123_wait_low", ioctl_wait, 1'b0);
    check("rd123_din", ioctl_din, 8'h5A);
    check("rd123_one_pulse", rd_pulses - p0, 1);

    // Top in-range address 0x7FF
    cyc();
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h7FF;
    cyc();
    ioctl_rd = 1'b0;
    cyc();
    cyc();
    smp();
    check("rd7ff_din", ioctl_din, 8'hA3);
    check("rd7ff_wait", ioctl_wait, 1'b0);

    // Out-of-range reads return fill byte without touching RAM
    p0 = rd_pulses;
    cyc();
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h800;
    smp();
    check("oob800_wait", ioctl_wait, 1'b0);
    cyc();
    ioctl_rd = 1'b0;
    smp();
    check("oob800_din", ioctl_din, 8'hFF);
    check("oob800_ram_rd", ram_rd, 1'b0);
    cyc();
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h1000123;
    cyc();
    ioctl_rd = 1'b0;
    cyc();
    smp();
    check("oob_hi_din", ioctl_din, 8'hFF);
    check("oob_no_ram_rd", rd_pulses - p0, 0);

    // Upload drops during LAT: read completes, then drain
    cyc();
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h010;
    cyc();
    ioctl_rd = 1'b0;
    cyc();
    ioctl_upload = 1'b0;
    smp();
    check("lat_drop_pause_held", pause_req, 1'b1);
    cyc();
    smp();
    check("lat_drop_din", ioctl_din, 8'hC7);
    check("lat_drop_pause_low", pause_req, 1'b0);
    cyc();
    smp();
    check("idle_pause_low", pause_req, 1'b0);
    check("idle_wait_low", ioctl_wait, 1'b0);

    // pause_ack never arrives: timeout after TIMEOUT cycles
    pause_ack = 1'b0;
    cyc();
    ioctl_upload = 1'b1;
    cyc();
    smp();
    n = ioctl_wait ? 1 : 0;
    while (n < 70000) begin
      cyc();
      smp();
      if (!ioctl_wait) break;
      n++;
    end
    check("timeout_cycles", n, 65535);
    check("timeout_flag_set", timeout_flag, 1'b1);
    check("timeout_pause_req", pause_req, 1'b1);
    cyc();
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h123;
    cyc();
    ioctl_rd = 1'b0;
    cyc();
    cyc();
    smp();
    check("timeout_rd_din", ioctl_din, 8'h5A);
    cyc();
    ioctl_upload = 1'b0;
    cyc();
    cyc();
    smp();
    check("flag_sticky", timeout_flag, 1'b1);
    check("flag_sticky_pause", pause_req, 1'b0);

    // Next upload clears the flag
    pause_ack = 1'b1;
    cyc();
    ioctl_upload = 1'b1;
    cyc();
    smp();
    check("flag_cleared", timeout_flag, 1'b0);
    cyc();
    smp();
    check("ack_ready_wait", ioctl_wait, 1'b0);

    // Index change mid-upload acts like upload falling
    cyc();
    ioctl_index = 8'd5;
    cyc();
    smp();
    check("idx_change_drain", pause_req, 1'b0);
    cyc();
    ioctl_index = 8'd4;
    cyc();
    cyc();
    smp();
    check("restart_ready", ioctl_wait, 1'b0);
    check("restart_pause_req", pause_req, 1'b1);

    // Async reset during FETCH
    cyc();
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h123;
    cyc();
    ioctl_rd = 1'b0;
    smp();
    check("pre_reset_fetch", ram_rd, 1'b1);
    #1;
    reset        = 1'b1;
    ioctl_upload = 1'b0;
    #1;
    check("areset_pause_req", pause_req, 1'b0);
    check("areset_ram_rd", ram_rd, 1'b0);
    check("areset_wait", ioctl_wait, 1'b0);
    check("areset_din", ioctl_din, 8'h00);
    check("areset_ram_addr", ram_addr, 11'h000);
    cyc();
    reset = 1'b0;

    // Foreign index: block stays idle and ignores strobes
    p0 = rd_pulses;
    cyc();
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd3;
    repeat (3) cyc();
    smp();
    check("idx3_pause_req", pause_req, 1'b0);
    check("idx3_wait", ioctl_wait, 1'b0);
    cyc();
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h123;
    smp();
    check("idx3_rd_wait", ioctl_wait, 1'b0);
    cyc();
    ioctl_rd = 1'b0;
    cyc();
    smp();
    check("idx3_no_ram_rd", rd_pulses - p0, 0);
    check("idx3_din", ioctl_din, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
